ins_fetch: RTL and testbench

- Instruction fetch unit; the producer side of the instruction path that ins_dec consumes.
- Owns the PC and runs the request/ack handshake with the 32-bit IMEM.
- Buffers one fetched word and presents it to the decoder, together with its PC and a valid strobe.
- Each 32-bit word holds two 16-bit instructions. The upper half is issued from the buffer without a second IMEM access. A decoder-flagged invalid instruction redirects the PC to BOOT_ADDR.

---
 rtl/simple_processor_pkg.sv | 27 ++
 rtl/ins_fetch.sv | 110 +++++++++++
 tb/tb_ins_fetch.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/simple_processor_pkg.sv
// Shared definitions for the simple processor instruction path.
//
// Contents:
//   DATA_WIDTH    - width of an IMEM word (two instructions)
//   ADDR_WIDTH    - byte-address width of the PC and IMEM address
//   INSTR_WIDTH   - width of one instruction (half a word)
//   HALF_SEL_BIT  - PC bit selecting the upper/lower half of a word
//   fetch_state_t - ins_fetch FSM encoding
//   word_addr()   - clears the byte/half offset bits of an address
package simple_processor_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int ADDR_WIDTH   = 32;
    localparam int INSTR_WIDTH  = 16;
    localparam int HALF_SEL_BIT = 1;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_ISSUE = 2'd2
    } fetch_state_t;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ins_fetch.sv
// Instruction fetch unit: owns the PC, fetches 32-bit words from IMEM and
// issues the two 16-bit instructions of each word to the decoder.
//
// Ports:
//   clk_i         in   system clock
//   rst_i         in   synchronous active-high reset
//   imem_req_o    out  IMEM read request, held until imem_ack_i
//   imem_addr_o   out  word-aligned IMEM address of the PC
//   imem_ack_i    in   IMEM read data valid (only honoured in FETCH_REQ)
//   imem_rdata_i  in   IMEM read data
//   dec_rdata_o   out  buffered word presented to the decoder
//   dec_ack_o     out  buffered word valid (high only in FETCH_ISSUE)
//   dec_addr_o    out  PC of the presented instruction; bit 1 selects the half
//   valid_pc_i    in   0 = decoder saw an invalid opcode, redirect to BOOT_ADDR
//   stall_i       in   downstream hold, instruction not consumed this cycle
//   pc_o          out  current PC
//   state_o       out  FSM state, debug visibility
//
// Handshakes:
//   IMEM side - imem_req_o rises in FETCH_REQ with a stable address and stays
//   high until the cycle imem_ack_i is sampled high; that cycle's imem_rdata_i
//   is captured. Decoder side - dec_ack_o is the valid; an instruction is
//   consumed on every FETCH_ISSUE cycle with stall_i low. imem_req_o and
//   dec_ack_o are never high together.
module ins_fetch
    import simple_processor_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [DATA_WIDTH-1:0] dec_rdata_o,
    output logic                  dec_ack_o,
    output logic [ADDR_WIDTH-1:0] dec_addr_o,
    input  logic                  valid_pc_i,
    input  logic                  stall_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output fetch_state_t          state_o
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(2);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        case (state_q)
            // One settling cycle after reset; a stale ack from a transaction
            // cut short by reset falls into this cycle and is dropped.
            FETCH_IDLE: begin
                state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (imem_ack_i) begin
                    buf_d   = imem_rdata_i;
                    state_d = FETCH_ISSUE;
                end
            end
            FETCH_ISSUE: begin
                if (!stall_i) begin
                    if (!valid_pc_i) begin
                        // Always refetch on redirect, even if BOOT_ADDR hits
                        // the buffered word: keeps the redirect path simple.
                        pc_d    = BOOT_ADDR;
                        state_d = FETCH_REQ;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                        // Lower half issued: the upper half is already in the
                        // buffer, so only leave ISSUE after the upper half.
                        if (pc_q[HALF_SEL_BIT]) begin
                            state_d = FETCH_REQ;
                        end
                    end
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH_IDLE;
            pc_q    <= BOOT_ADDR;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    assign imem_req_o  = (state_q == FETCH_REQ);
    assign imem_addr_o = word_addr(pc_q);
    assign dec_ack_o   = (state_q == FETCH_ISSUE);
    assign dec_rdata_o = buf_q;
    assign dec_addr_o  = pc_q;
    assign pc_o        = pc_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_ins_fetch.sv
module tb_ins_fetch;
  import simple_processor_pkg::*;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Three instances differing only in BOOT_ADDR: 0, 0x100, 0xFFFF_FFFE.
  logic                  rst      [3];
  logic                  ack      [3];
  logic [DATA_WIDTH-1:0] rdata    [3];
  logic                  valid_pc [3];
  logic                  stall    [3];
  logic                  req      [3];
  logic [ADDR_WIDTH-1:0] iaddr    [3];
  logic [DATA_WIDTH-1:0] drdata   [3];
  logic                  dack     [3];
  logic [ADDR_WIDTH-1:0] daddr    [3];
  logic [ADDR_WIDTH-1:0] pc       [3];
  fetch_state_t          st       [3];

  ins_fetch #(.BOOT_ADDR(32'h0000_0000)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .imem_req_o(req[0]), .imem_addr_o(iaddr[0]),
    .imem_ack_i(ack[0]), .imem_rdata_i(rdata[0]), .dec_rdata_o(drdata[0]),
    .dec_ack_o(dack[0]), .dec_addr_o(daddr[0]), .valid_pc_i(valid_pc[0]),
    .stall_i(stall[0]), .pc_o(pc[0]), .state_o(st[0])
  );
  ins_fetch #(.BOOT_ADDR(32'h0000_0100)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .imem_req_o(req[1]), .imem_addr_o(iaddr[1]),
    .imem_ack_i(ack[1]), .imem_rdata_i(rdata[1]), .dec_rdata_o(drdata[1]),
    .dec_ack_o(dack[1]), .dec_addr_o(daddr[1]), .valid_pc_i(valid_pc[1]),
    .stall_i(stall[1]), .pc_o(pc[1]), .state_o(st[1])
  );
  ins_fetch #(.BOOT_ADDR(32'hFFFF_FFFE)) u_dut2 (
    .clk_i(clk), .rst_i(rst[2]), .imem_req_o(req[2]), .imem_addr_o(iaddr[2]),
    .imem_ack_i(ack[2]), .imem_rdata_i(rdata[2]), .dec_rdata_o(drdata[2]),
    .dec_ack_o(dack[2]), .dec_addr_o(daddr[2]), .valid_pc_i(valid_pc[2]),
    .stall_i(stall[2]), .pc_o(pc[2]), .state_o(st[2])
  );

  function automatic logic [31:0] boot_of(input int i);
    case (i)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0100;
      default: return 32'hFFFF_FFFE;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    step();
    chk("rst_req",    32'(req[i]),   32'd0);
    chk("rst_dack",   32'(dack[i]),  32'd0);
    chk("rst_drdata", drdata[i],     32'd0);
    chk("rst_daddr",  daddr[i],      boot_of(i));
    chk("rst_pc",     pc[i],         boot_of(i));
    chk("rst_iaddr",  iaddr[i],      {boot_of(i) >> 2, 2'b00});
    chk("rst_state",  32'(st[i]),    32'(FETCH_IDLE));
    rst[i] = 1'b0;
  endtask

  task automatic wait_req(input int i);
    for (int k = 0; k < 20; k++) begin
      if (req[i]) return;
      step();
    end
    chk("req_timeout", 32'(req[i]), 32'd1);
  endtask

  // Answer the pending request after lat cycles, checking it stays stable.
  task automatic serve(input int i, input logic [31:0] word, input int lat);
    logic [31:0] a0;
    a0 = iaddr[i];
    for (int k = 1; k < lat; k++) begin
      chk("lat_req",   32'(req[i]),  32'd1);
      chk("lat_iaddr", iaddr[i],     a0);
      chk("lat_dack",  32'(dack[i]), 32'd0);
      step();
    end
    ack[i]   = 1'b1;
    rdata[i] = word;
    step();
    ack[i]   = 1'b0;
    rdata[i] = 32'h0;
    chk("issue_dack",   32'(dack[i]), 32'd1);
    chk("issue_drdata", drdata[i],    word);
    chk("issue_req",    32'(req[i]),  32'd0);
  endtask

  // Consume instructions (1-cycle IMEM) until the target PC is presented.
  task automatic run_to(input int i, input logic [31:0] target);
    for (int k = 0; k < 100; k++) begin
      if (dack[i] && daddr[i] == target) return;
      if (req[i]) begin
        ack[i]   = 1'b1;
        rdata[i] = 32'hA000_0000 | iaddr[i];
      end
      step();
      ack[i] = 1'b0;
    end
    chk("run_to_timeout", daddr[i], target);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; ack[i] = 1'b0; rdata[i] = '0;
      valid_pc[i] = 1'b1; stall[i] = 1'b0;
    end
    step();

    // Basic fetch, BOOT_ADDR=0, 1-cycle IMEM.
    do_reset(0);
    step();
    chk("a_req1",   32'(req[0]), 32'd1);
    chk("a_iaddr1", iaddr[0],    32'h0);
    serve(0, 32'h5A21_1230, 1);
    chk("a_daddr0", daddr[0], 32'h0);
    step();
    chk("a_daddr2", daddr[0],    32'h2);
    chk("a_dack2",  32'(dack[0]), 32'd1);
    chk("a_noreq2", 32'(req[0]), 32'd0);

    // Stall three cycles on the upper half.
    stall[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_daddr",  daddr[0],     32'h2);
      chk("stall_dack",   32'(dack[0]), 32'd1);
      chk("stall_req",    32'(req[0]),  32'd0);
      chk("stall_drdata", drdata[0],    32'h5A21_1230);
    end
    stall[0] = 1'b0;
    step();
    chk("a_req4",   32'(req[0]), 32'd1);
    chk("a_iaddr4", iaddr[0],    32'h4);
    chk("a_dack4",  32'(dack[0]), 32'd0);

    // 4-cycle IMEM latency.
    serve(0, 32'hCAFE_0004, 4);
    chk("a_daddr4", daddr[0], 32'h4);
    step();
    chk("a_daddr6", daddr[0], 32'h6);
    step();
    chk("a_iaddr8", iaddr[0], 32'h8);

    // Reset mid-request, then a stray ack in the idle cycle.
    do_reset(0);
    ack[0]   = 1'b1;
    rdata[0] = 32'hDEAD_BEEF;
    step();
    ack[0]   = 1'b0;
    rdata[0] = 32'h0;
    chk("stray_req",    32'(req[0]),  32'd1);
    chk("stray_iaddr",  iaddr[0],     32'h0);
    chk("stray_dack",   32'(dack[0]), 32'd0);
    chk("stray_drdata", drdata[0],    32'h0);
    serve(0, 32'h1111_2222, 2);
    chk("stray_daddr", daddr[0], 32'h0);

    // Redirect with BOOT_ADDR=0x100, first held off by a stall.
    do_reset(1);
    wait_req(1);
    chk("b_iaddr0", iaddr[1], 32'h100);
    run_to(1, 32'h112);
    chk("b_at112", daddr[1], 32'h112);
    valid_pc[1] = 1'b0;
    stall[1]    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("redir_hold_daddr", daddr[1],     32'h112);
      chk("redir_hold_dack",  32'(dack[1]), 32'd1);
      chk("redir_hold_req",   32'(req[1]),  32'd0);
    end
    stall[1] = 1'b0;
    step();
    valid_pc[1] = 1'b1;
    chk("redir_req",   32'(req[1]),  32'd1);
    chk("redir_iaddr", iaddr[1],     32'h100);
    chk("redir_dack",  32'(dack[1]), 32'd0);
    chk("redir_pc",    pc[1],        32'h100);
    serve(1, 32'h0BAD_F00D, 2);
    chk("redir_daddr", daddr[1], 32'h100);

    // PC wrap from 0xFFFF_FFFE to 0.
    do_reset(2);
    wait_req(2);
    chk("c_iaddr", iaddr[2], 32'hFFFF_FFFC);
    serve(2, 32'h7777_8888, 1);
    chk("c_daddr", daddr[2], 32'hFFFF_FFFE);
    step();
    chk("wrap_pc",    pc[2],        32'h0);
    chk("wrap_req",   32'(req[2]),  32'd1);
    chk("wrap_iaddr", iaddr[2],     32'h0);
    chk("wrap_dack",  32'(dack[2]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
